// File: rtl/mult_div_ctrl.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO, emulates the
// fixed multi-cycle latency and raises a stall request to the hazard unit.
module mult_div_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hi,
    input  logic             md_use_d,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   pend_hi_q;
    logic [WIDTH-1:0]   pend_lo_q;
    logic               pend_wr_q;

    logic               long_op;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   abs_b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quot_u;
    logic [WIDTH-1:0]   rem_u;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_wr;

    assign long_op = (op <= OP_DIVU);

    // Products: both operands widened to 2*WIDTH so the product is exact.
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed division on magnitudes; the most-negative / -1 case falls out
    // naturally as 0x80..0 with a zero remainder.
    assign a_neg      = a[WIDTH-1];
    assign b_neg      = b[WIDTH-1];
    assign abs_a      = a_neg ? -a : a;
    assign abs_b      = b_neg ? -b : b;
    assign b_safe     = (b == '0) ? WIDTH'(1) : b;
    assign abs_b_safe = (b == '0) ? WIDTH'(1) : abs_b;
    assign q_mag      = abs_a / abs_b_safe;
    assign r_mag      = abs_a % abs_b_safe;
    assign quot_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem_s      = a_neg ? -r_mag : r_mag;
    assign quot_u     = a / b_safe;
    assign rem_u      = a % b_safe;

    // Result selection for the op being issued; divide by zero suppresses writeback.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b1;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_lo = quot_s;
                res_hi = rem_s;
                res_wr = (b != '0);
            end
            OP_DIVU: begin
                res_lo = quot_u;
                res_hi = rem_u;
                res_wr = (b != '0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Sequencer: IDLE accepts commands, BUSY counts down and commits pending HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (long_op) begin
                            pend_hi_q <= res_hi;
                            pend_lo_q <= res_lo;
                            pend_wr_q <= res_wr;
                            cnt_q     <= (op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            busy_q    <= 1'b1;
                            state_q   <= ST_BUSY;
                        end else if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q     <= '0;
                        pend_wr_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = md_use_d & (busy_q | (start & long_op));
    assign md_out    = rd_hi ? hi_q : lo_q;

endmodule
